// File: rtl/ifs_capture_ctrl_if.sv
// ifs_capture_ctrl_if: lane control, input-cell bit/clear and word handshake of one capture lane.
interface ifs_capture_ctrl_if #(parameter int WIDTH = 8);
   logic EN, RESYNC, Q_IN, CD_OUT, VALID, READY, LOCKED, OVERRUN;
   logic [WIDTH-1:0] DATA;
   modport master (output EN, RESYNC, Q_IN, READY, input CD_OUT, DATA, VALID, LOCKED, OVERRUN);
   modport slave (input EN, RESYNC, Q_IN, READY, output CD_OUT, DATA, VALID, LOCKED, OVERRUN);
endinterface

// File: rtl/ifs_capture_ctrl.sv
// ifs_capture_ctrl: clears an ECP5 input-register cell, hunts for a sync word, then
// deserializes the lane MSB-first into WIDTH-bit words on a valid/ready port.
module ifs_capture_ctrl #(
   parameter int WIDTH = 8,
   parameter logic [WIDTH-1:0] SYNC = WIDTH'(8'hA5),
   parameter int CLR_CYC = 2
) (
   input logic SCLK,
   input logic RSTN,
   ifs_capture_ctrl_if.slave lane
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [2:0] {IDLE, CLEAR, PRIME, HUNT, SHIFT} state_t;
   state_t state;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] nxt;
   logic [CW-1:0] bit_cnt;
   logic [3:0] clr_cnt;
   logic done;
   assign nxt = {shift_q[WIDTH-2:0], lane.Q_IN};
   assign done = state == SHIFT && bit_cnt == LAST;
   always_ff @(posedge SCLK or negedge RSTN) begin
      if (!RSTN) begin
         state <= IDLE;
         lane.CD_OUT <= 1'b1;
         lane.DATA <= '0;
         lane.VALID <= 1'b0;
         lane.LOCKED <= 1'b0;
         lane.OVERRUN <= 1'b0;
         shift_q <= '0;
         bit_cnt <= '0;
         clr_cnt <= '0;
      end else if (state != IDLE && !lane.EN) begin
         state <= IDLE;
         lane.CD_OUT <= 1'b1;
         lane.VALID <= 1'b0;
         lane.LOCKED <= 1'b0;
         lane.OVERRUN <= 1'b0;
      end else begin
         if (lane.VALID && lane.READY) lane.VALID <= 1'b0;
         // a completed word loads only into an empty or draining holding register
         if (done) begin
            if (!lane.VALID || lane.READY) begin
               lane.DATA <= nxt;
               lane.VALID <= 1'b1;
            end else lane.OVERRUN <= 1'b1;
         end
         case (state)
            IDLE: begin
               lane.CD_OUT <= 1'b1;
               lane.LOCKED <= 1'b0;
               lane.OVERRUN <= 1'b0;
               if (lane.EN) begin
                  state <= CLEAR;
                  clr_cnt <= 4'(CLR_CYC - 1);
               end
            end
            CLEAR: begin
               if (clr_cnt == '0) begin
                  state <= PRIME;
                  lane.CD_OUT <= 1'b0;
               end else clr_cnt <= clr_cnt - 4'd1;
            end
            PRIME: state <= HUNT;
            HUNT, SHIFT: begin
               shift_q <= nxt;
               bit_cnt <= (state == SHIFT && !lane.RESYNC && bit_cnt != LAST) ? bit_cnt + 1'b1 : '0;
               if (lane.RESYNC) begin
                  state <= HUNT;
                  lane.LOCKED <= 1'b0;
               end else if (state == HUNT && nxt == SYNC) begin
                  state <= SHIFT;
                  lane.LOCKED <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ifs_capture_ctrl.sv
// tb_ifs_capture_ctrl: directed scenarios for the capture lane sequencer.
module tb_ifs_capture_ctrl;
   logic SCLK = 1'b0;
   logic RSTN = 1'b0;
   int n_checks = 0;
   int n_fail = 0;
   logic [7:0] w;
   logic [9:0] seq;
   ifs_capture_ctrl_if #(.WIDTH(8)) bi ();
   ifs_capture_ctrl #(.WIDTH(8), .SYNC(8'hA5), .CLR_CYC(2)) dut (.SCLK(SCLK), .RSTN(RSTN), .lane(bi));
   always #5 SCLK = ~SCLK;

   task automatic tick;
      @(posedge SCLK);
      #1;
   endtask

   task automatic put(input logic b);
      bi.Q_IN = b;
      tick();
   endtask

   // flags are {CD_OUT, VALID, LOCKED, OVERRUN}
   task automatic test_reset;
      bi.EN = 1'b0; bi.RESYNC = 1'b0; bi.Q_IN = 1'b0; bi.READY = 1'b0;
      #12;
      n_checks++; if ({bi.CD_OUT, bi.VALID, bi.LOCKED, bi.OVERRUN} !== 4'b1000) begin n_fail++; $display("FAIL reset_flags: got %b want 1000", {bi.CD_OUT, bi.VALID, bi.LOCKED, bi.OVERRUN}); end
      n_checks++; if (bi.DATA !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bi.DATA); end
      tick();
      RSTN = 1'b1;
      tick();
      n_checks++; if ({bi.CD_OUT, bi.VALID, bi.LOCKED, bi.OVERRUN} !== 4'b1000) begin n_fail++; $display("FAIL idle_flags: got %b want 1000", {bi.CD_OUT, bi.VALID, bi.LOCKED, bi.OVERRUN}); end
   endtask

   task automatic test_enable_clear;
      logic [3:0] exp [4] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000};
      bi.EN = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_checks++; if ({bi.CD_OUT, bi.VALID, bi.LOCKED, bi.OVERRUN} !== exp[k]) begin n_fail++; $display("FAIL clear_seq[%0d]: got %b want %b", k, {bi.CD_OUT, bi.VALID, bi.LOCKED, bi.OVERRUN}, exp[k]); end
      end
   endtask

   task automatic test_lock_and_word;
      seq = 10'b0010100101;
      for (int i = 9; i >= 0; i--) begin
         put(seq[i]);
         n_checks++; if (bi.LOCKED !== (i == 0)) begin n_fail++; $display("FAIL hunt_locked[%0d]: got %b want %b", i, bi.LOCKED, i == 0); end
      end
      bi.READY = 1'b1;
      w = 8'h3C;
      for (int i = 7; i >= 0; i--) begin
         put(w[i]);
         n_checks++; if (bi.VALID !== (i == 0)) begin n_fail++; $display("FAIL word3c_valid[%0d]: got %b want %b", i, bi.VALID, i == 0); end
      end
      n_checks++; if (bi.DATA !== 8'h3C) begin n_fail++; $display("FAIL word3c_data: got %h want 3c", bi.DATA); end
   endtask

   task automatic test_overrun;
      w = 8'h11;
      for (int i = 7; i >= 0; i--) begin
         put(w[i]);
         if (i == 7) begin
            n_checks++; if (bi.VALID !== 1'b0) begin n_fail++; $display("FAIL consume3c_valid: got %b want 0", bi.VALID); end
            bi.READY = 1'b0;
         end
      end
      n_checks++; if ({bi.VALID, bi.OVERRUN, bi.DATA} !== {2'b10, 8'h11}) begin n_fail++; $display("FAIL word11: got v=%b o=%b d=%h want v=1 o=0 d=11", bi.VALID, bi.OVERRUN, bi.DATA); end
      w = 8'h22;
      for (int i = 7; i >= 0; i--) begin
         put(w[i]);
         n_checks++; if (bi.OVERRUN !== (i == 0)) begin n_fail++; $display("FAIL overrun[%0d]: got %b want %b", i, bi.OVERRUN, i == 0); end
      end
      n_checks++; if ({bi.VALID, bi.DATA} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL held11: got v=%b d=%h want v=1 d=11", bi.VALID, bi.DATA); end
      bi.READY = 1'b1;
      w = 8'h33;
      for (int i = 7; i >= 0; i--) begin
         put(w[i]);
         if (i == 7) begin
            n_checks++; if (bi.VALID !== 1'b0) begin n_fail++; $display("FAIL consume11_valid: got %b want 0", bi.VALID); end
         end
      end
      n_checks++; if ({bi.VALID, bi.OVERRUN, bi.DATA} !== {2'b11, 8'h33}) begin n_fail++; $display("FAIL word33: got v=%b o=%b d=%h want v=1 o=1 d=33", bi.VALID, bi.OVERRUN, bi.DATA); end
   endtask

   task automatic test_resync;
      for (int i = 0; i < 4; i++) put(1'b1);
      bi.RESYNC = 1'b1;
      put(1'b1);
      bi.RESYNC = 1'b0;
      n_checks++; if ({bi.VALID, bi.LOCKED} !== 2'b00) begin n_fail++; $display("FAIL resync_drop: got v=%b l=%b want v=0 l=0", bi.VALID, bi.LOCKED); end
      for (int i = 0; i < 3; i++) put(1'b1);
      w = 8'hA5;
      for (int i = 7; i >= 0; i--) begin
         put(w[i]);
         n_checks++; if ({bi.VALID, bi.LOCKED} !== {1'b0, i == 0}) begin n_fail++; $display("FAIL rehunt[%0d]: got v=%b l=%b want v=0 l=%b", i, bi.VALID, bi.LOCKED, i == 0); end
      end
      w = 8'h5A;
      for (int i = 7; i >= 0; i--) begin
         put(w[i]);
         n_checks++; if (bi.VALID !== (i == 0)) begin n_fail++; $display("FAIL word5a_valid[%0d]: got %b want %b", i, bi.VALID, i == 0); end
      end
      n_checks++; if ({bi.OVERRUN, bi.DATA} !== {1'b1, 8'h5A}) begin n_fail++; $display("FAIL word5a: got o=%b d=%h want o=1 d=5a", bi.OVERRUN, bi.DATA); end
   endtask

   task automatic test_en_drop;
      logic [3:0] exp [5] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
      bi.READY = 1'b0;
      bi.EN = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) bi.EN = 1'b1;
         tick();
         n_checks++; if ({bi.CD_OUT, bi.VALID, bi.LOCKED, bi.OVERRUN} !== exp[k]) begin n_fail++; $display("FAIL endrop_flags[%0d]: got %b want %b", k, {bi.CD_OUT, bi.VALID, bi.LOCKED, bi.OVERRUN}, exp[k]); end
         n_checks++; if (bi.DATA !== 8'h5A) begin n_fail++; $display("FAIL endrop_data[%0d]: got %h want 5a", k, bi.DATA); end
      end
   endtask

   task automatic test_async_reset;
      logic [3:0] exp [4] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000};
      tick();
      w = 8'hA5;
      for (int i = 7; i >= 0; i--) begin
         put(w[i]);
         n_checks++; if (bi.LOCKED !== (i == 0)) begin n_fail++; $display("FAIL relock[%0d]: got %b want %b", i, bi.LOCKED, i == 0); end
      end
      put(1'b1); put(1'b0); put(1'b1); put(1'b1);
      #3 RSTN = 1'b0;
      #1;
      n_checks++; if ({bi.CD_OUT, bi.VALID, bi.LOCKED, bi.OVERRUN, bi.DATA} !== {4'b1000, 8'h00}) begin n_fail++; $display("FAIL async_reset: got %b %h want 1000 00", {bi.CD_OUT, bi.VALID, bi.LOCKED, bi.OVERRUN}, bi.DATA); end
      #1 RSTN = 1'b1;
      bi.EN = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k == 1) bi.EN = 1'b1;
         tick();
         n_checks++; if ({bi.CD_OUT, bi.VALID, bi.LOCKED, bi.OVERRUN, bi.DATA} !== {exp[k], 8'h00}) begin n_fail++; $display("FAIL post_reset[%0d]: got %b %h want %b 00", k, {bi.CD_OUT, bi.VALID, bi.LOCKED, bi.OVERRUN}, bi.DATA, exp[k]); end
      end
   endtask

   initial begin
      test_reset();
      test_enable_clear();
      test_lock_and_word();
      test_overrun();
      test_resync();
      test_en_drop();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ifs_capture_ctrl.md
Name: ifs_capture_ctrl

Overview:
- Sequencer for one lane of ECP5 input-register cells: a synchronous-clear, SCLK-clocked input flop with active-high CD.
- Drives the cell's CD clear and consumes the cell's registered output bit.
- Hunts for a sync pattern, then deserializes the lane MSB-first into WIDTH-bit words.
- Presents words on a valid/ready interface to the fabric, with overrun detection.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- SYNC, 8'hA5, WIDTH-bit sync pattern that marks the word boundary.
- CLR_CYC, 2, number of SCLK cycles CD_OUT is held high on each enable; legal range 1..15.

Ports:
- SCLK  input  1  clock, shared with the input-register cell.
- RSTN  input  1  asynchronous active-low reset.
- EN  input  1  lane enable.
- RESYNC  input  1  single-cycle pulse; drop lock and re-hunt.
- Q_IN  input  1  registered bit from the input cell's Q.
- CD_OUT  output  1  clear to the input cell's CD; active high.
- DATA  output  WIDTH  assembled word.
- VALID  output  1  DATA holds an unconsumed word.
- READY  input  1  consumer accepts DATA when VALID & READY.
- LOCKED  output  1  sync found; lane is deserializing.
- OVERRUN  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset: RSTN low asynchronously forces the following, and state=IDLE.
  - CD_OUT=1
  - DATA=0, VALID=0, LOCKED=0, OVERRUN=0
  - shift register=0, bit counter=0, clear counter=0
- All other logic is synchronous to the SCLK rising edge.
- States: IDLE, CLEAR, PRIME, HUNT, SHIFT.
- IDLE:
  - CD_OUT=1, LOCKED=0, OVERRUN cleared.
  - EN=1 → CLEAR; clear counter loads CLR_CYC-1.
- CLEAR:
  - CD_OUT=1; counter decrements.
  - At counter 0 → PRIME, with CD_OUT=0 from the next cycle.
- PRIME:
  - Exactly one cycle, covering the cell's one-cycle register latency.
  - Q_IN is ignored (it still reflects the cleared value 0). → HUNT.
- HUNT:
  - Every cycle: shift register <= {shift[WIDTH-2:0], Q_IN}.
  - When the updated value equals SYNC → SHIFT; LOCKED=1 from the next cycle; bit counter=0.
  - The sync word itself is never output.
  - Fewer than WIDTH bits shifted since PRIME may still match, because the shift register was reset to 0; this is accepted behaviour.
- SHIFT:
  - Every cycle shift in Q_IN and increment the bit counter.
  - When the counter reaches WIDTH-1, the word is complete: the value including this cycle's bit is offered to the output stage, and the counter wraps to 0.
  - Steady-state throughput: one word per WIDTH cycles.
- Output stage (single holding register):
  - Handshake: a VALID & READY cycle consumes the word; VALID falls next cycle unless a new word loads the same cycle.
  - Word completes, and VALID=0 or READY=1 this cycle: DATA<=word, VALID=1 next cycle.
  - Word completes, and VALID=1 and READY=0: the new word is dropped, DATA/VALID are unchanged, OVERRUN<=1.
  - DATA is stable while VALID=1 and READY=0.
- RESYNC=1 in SHIFT or HUNT:
  - → HUNT next cycle; LOCKED=0; bit counter=0; shift register is kept.
  - A word completing in the same cycle is still delivered.
  - RESYNC is ignored in IDLE, CLEAR and PRIME.
- EN=0 in any non-IDLE state:
  - → IDLE next cycle; CD_OUT=1 next cycle; VALID=0; LOCKED=0.
  - DATA retains its last value.
  - EN takes priority over RESYNC and word completion.
- EN re-asserted: a full CLEAR/PRIME sequence always runs again.
- OVERRUN is cleared only by reset or by passing through IDLE.
- RSTN asserted mid-word: immediate return to reset values; no partial word is ever output.

Test Plan:
- Reset, then EN=1 → CD_OUT high for exactly 2 cycles after the EN edge, low from cycle 3 on; LOCKED=0 through PRIME.
- Feed bits 0,0,1,0,1,0,0,1,0,1 then 8'h3C MSB-first, READY=1 → LOCKED=1 after A5 detection; VALID pulses for 1 cycle with DATA=8'h3C exactly 8 cycles after lock.
- Stream 8'h11, 8'h22 with READY=0 → DATA=8'h11 held; OVERRUN=1 after the second word completes; READY=1 then consumes 8'h11; the next word arrives normally.
- Pulse RESYNC mid-word (4 bits into 8'hFF) → LOCKED=0 next cycle; no VALID until A5 is seen again, then the following byte is output.
- Drop EN while VALID=1 → next cycle VALID=0, CD_OUT=1, OVERRUN=0, DATA unchanged; re-enable replays CLEAR for 2 cycles.
- Assert RSTN low asynchronously mid-SHIFT (between edges) → all outputs reset immediately; after release, CD_OUT=1 and state=IDLE.
